regs: RTL and testbench

- Register file and internal data bus of the 4-bit microcoded CPU core.
- Holds A, B, TEMPA, TEMPB, X (12b), Y (12b), SP (8b) and the flags C/Z/D/I.
- Each microinstruction moves one nibble from a selected source to a selected destination. It can also access data memory through MX, MY, Mn or MSP, and post-increment an index register.
- Sits between the microcode sequencer, the ALU and the data RAM.

---
 rtl/regs_pkg.sv | 55 +++++
 rtl/regs.sv | 155 +++++++++++++++
 tb/tb_regs.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regs_pkg.sv
// Shared types for the 4-bit CPU register file: microcode cycle phases,
// bus source/destination selectors and post-increment selectors.
`default_nettype none

package regs_pkg;

   typedef enum logic [1:0] {
      CYCLE_NONE      = 2'd0,
      CYCLE_REG_FETCH = 2'd1,
      CYCLE_REG_WRITE = 2'd2
   } microcode_cycle;

   typedef enum logic [4:0] {
      REG_A              = 5'd0,
      REG_B              = 5'd1,
      REG_TEMPA          = 5'd2,
      REG_TEMPB          = 5'd3,
      REG_XL             = 5'd4,
      REG_XH             = 5'd5,
      REG_XP             = 5'd6,
      REG_YL             = 5'd7,
      REG_YH             = 5'd8,
      REG_YP             = 5'd9,
      REG_SPL            = 5'd10,
      REG_SPH            = 5'd11,
      REG_IMM            = 5'd12,
      REG_ALU            = 5'd13,
      REG_ALU_WITH_FLAGS = 5'd14,
      REG_HARDCODED_1    = 5'd15,
      REG_FLAGS          = 5'd16,
      REG_MX             = 5'd17,
      REG_MY             = 5'd18,
      REG_MN             = 5'd19,
      REG_MSP            = 5'd20
   } reg_type;

   typedef enum logic [1:0] {
      REG_NONE = 2'd0,
      REG_XHL  = 2'd1,
      REG_YHL  = 2'd2,
      REG_SP   = 2'd3
   } reg_inc_type;

   function automatic logic is_mem_sel(input reg_type sel);
      logic r;
      case (sel)
         REG_MX, REG_MY, REG_MN, REG_MSP: r = 1'b1;
         default:                         r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/regs.sv
// Register file and nibble-wide internal bus of the 4-bit microcoded CPU,
// with data-RAM address generation and index post-increment.
`default_nettype none

module regs
   import regs_pkg::*;
(
   input  logic           clk,
   input  logic           reset_n,
   input  microcode_cycle current_cycle,
   input  reg_type        bus_input_selector,
   input  reg_type        bus_output_selector,
   input  reg_inc_type    increment_selector,
   input  logic [3:0]     alu,
   input  logic           alu_zero,
   input  logic           alu_carry,
   input  logic [3:0]     immed,
   output logic           memory_write_en,
   output logic [11:0]    memory_addr,
   output logic [3:0]     memory_write_data,
   input  logic [3:0]     memory_read_data
);

   logic [3:0]  a_q, a_d, b_q, b_d, tempa_q, tempa_d, tempb_q, tempb_d;
   logic [11:0] x_q, x_d, y_q, y_d;
   logic [7:0]  sp_q, sp_d;
   logic        c_q, c_d, z_q, z_d, d_q, d_d, i_q, i_d;
   logic [11:0] addr_q, addr_d;

   logic [3:0]  w_bus;
   logic [11:0] w_calc_addr;
   reg_type     w_addr_sel;

   always_comb begin
      w_bus = 4'h0;
      case (bus_input_selector)
         REG_A:              w_bus = a_q;
         REG_B:              w_bus = b_q;
         REG_TEMPA:          w_bus = tempa_q;
         REG_TEMPB:          w_bus = tempb_q;
         REG_XL:             w_bus = x_q[3:0];
         REG_XH:             w_bus = x_q[7:4];
         REG_XP:             w_bus = x_q[11:8];
         REG_YL:             w_bus = y_q[3:0];
         REG_YH:             w_bus = y_q[7:4];
         REG_YP:             w_bus = y_q[11:8];
         REG_SPL:            w_bus = sp_q[3:0];
         REG_SPH:            w_bus = sp_q[7:4];
         REG_IMM:            w_bus = immed;
         REG_ALU:            w_bus = alu;
         REG_ALU_WITH_FLAGS: w_bus = alu;
         REG_HARDCODED_1:    w_bus = 4'h1;
         REG_FLAGS:          w_bus = {i_q, d_q, z_q, c_q};
         REG_MX, REG_MY, REG_MN, REG_MSP: w_bus = memory_read_data;
         default:            w_bus = 4'h0;
      endcase
   end

   // A memory source owns the address even when the destination is also memory.
   always_comb begin
      w_addr_sel  = is_mem_sel(bus_input_selector) ? bus_input_selector : bus_output_selector;
      w_calc_addr = 12'h000;
      case (w_addr_sel)
         REG_MX:  w_calc_addr = x_q;
         REG_MY:  w_calc_addr = y_q;
         REG_MN:  w_calc_addr = {8'h00, immed};
         REG_MSP: w_calc_addr = {4'h0, sp_q};
         default: w_calc_addr = 12'h000;
      endcase
   end

   assign memory_addr       = (current_cycle == CYCLE_REG_FETCH) ? w_calc_addr : addr_q;
   assign memory_write_en   = (current_cycle == CYCLE_REG_WRITE) && is_mem_sel(bus_output_selector);
   assign memory_write_data = w_bus;

   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      tempa_d = tempa_q;
      tempb_d = tempb_q;
      x_d     = x_q;
      y_d     = y_q;
      sp_d    = sp_q;
      c_d     = c_q;
      z_d     = z_q;
      d_d     = d_q;
      i_d     = i_q;
      addr_d  = addr_q;
      if (current_cycle == CYCLE_REG_FETCH) begin
         addr_d = w_calc_addr;
      end
      if (current_cycle == CYCLE_REG_WRITE) begin
         // Increment first so a destination nibble write overrides it.
         case (increment_selector)
            REG_XHL: x_d[7:0] = x_q[7:0] + 8'd1;
            REG_YHL: y_d[7:0] = y_q[7:0] + 8'd1;
            REG_SP:  sp_d     = sp_q + 8'd1;
            default: ;
         endcase
         if (bus_input_selector == REG_ALU_WITH_FLAGS) begin
            c_d = alu_carry;
            z_d = alu_zero;
         end
         case (bus_output_selector)
            REG_A:     a_d        = w_bus;
            REG_B:     b_d        = w_bus;
            REG_TEMPA: tempa_d    = w_bus;
            REG_TEMPB: tempb_d    = w_bus;
            REG_XL:    x_d[3:0]   = w_bus;
            REG_XH:    x_d[7:4]   = w_bus;
            REG_XP:    x_d[11:8]  = w_bus;
            REG_YL:    y_d[3:0]   = w_bus;
            REG_YH:    y_d[7:4]   = w_bus;
            REG_YP:    y_d[11:8]  = w_bus;
            REG_SPL:   sp_d[3:0]  = w_bus;
            REG_SPH:   sp_d[7:4]  = w_bus;
            REG_FLAGS: {i_d, d_d, z_d, c_d} = w_bus;
            default:   ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_q     <= 4'h0;
         b_q     <= 4'h0;
         tempa_q <= 4'h0;
         tempb_q <= 4'h0;
         x_q     <= 12'h000;
         y_q     <= 12'h000;
         sp_q    <= 8'h00;
         c_q     <= 1'b0;
         z_q     <= 1'b0;
         d_q     <= 1'b0;
         i_q     <= 1'b0;
         addr_q  <= 12'h000;
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         tempa_q <= tempa_d;
         tempb_q <= tempb_d;
         x_q     <= x_d;
         y_q     <= y_d;
         sp_q    <= sp_d;
         c_q     <= c_d;
         z_q     <= z_d;
         d_q     <= d_d;
         i_q     <= i_d;
         addr_q  <= addr_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_regs.sv
// Self-checking bench for regs: directed microinstruction sequence followed by
// random microinstructions against a behavioural register/RAM model.
`default_nettype none

module tb_regs;
   import regs_pkg::*;

   logic           clk;
   logic           reset_n;
   microcode_cycle current_cycle;
   reg_type        bus_input_selector;
   reg_type        bus_output_selector;
   reg_inc_type    increment_selector;
   logic [3:0]     alu;
   logic           alu_zero;
   logic           alu_carry;
   logic [3:0]     immed;
   logic           memory_write_en;
   logic [11:0]    memory_addr;
   logic [3:0]     memory_write_data;
   logic [3:0]     memory_read_data;

   int checks = 0;
   int errors = 0;

   regs dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .current_cycle       (current_cycle),
      .bus_input_selector  (bus_input_selector),
      .bus_output_selector (bus_output_selector),
      .increment_selector  (increment_selector),
      .alu                 (alu),
      .alu_zero            (alu_zero),
      .alu_carry           (alu_carry),
      .immed               (immed),
      .memory_write_en     (memory_write_en),
      .memory_addr         (memory_addr),
      .memory_write_data   (memory_write_data),
      .memory_read_data    (memory_read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Data RAM: synchronous read, one clock latency; cleared while in reset.
   logic [3:0] ram [4096];
   always @(posedge clk) begin
      if (!reset_n) begin
         for (int k = 0; k < 4096; k++) ram[k] <= 4'h0;
         memory_read_data <= 4'h0;
      end else begin
         if (memory_write_en) ram[memory_addr] <= memory_write_data;
         memory_read_data <= ram[memory_addr];
      end
   end

   // Reference model state
   logic [3:0]  m_a, m_b, m_ta, m_tb;
   logic [11:0] m_x, m_y, m_addr;
   logic [7:0]  m_sp;
   logic        m_c, m_z, m_d, m_i;
   logic [3:0]  exp_mem [4096];
   logic [3:0]  last_wdata;

   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic logic is_mem(input reg_type r);
      return (r == REG_MX) || (r == REG_MY) || (r == REG_MN) || (r == REG_MSP);
   endfunction

   function automatic logic [3:0] model_bus(input reg_type s, input logic [3:0] im,
                                            input logic [3:0] al, input logic [3:0] rd);
      case (s)
         REG_A:     return m_a;
         REG_B:     return m_b;
         REG_TEMPA: return m_ta;
         REG_TEMPB: return m_tb;
         REG_XL:    return m_x[3:0];
         REG_XH:    return m_x[7:4];
         REG_XP:    return m_x[11:8];
         REG_YL:    return m_y[3:0];
         REG_YH:    return m_y[7:4];
         REG_YP:    return m_y[11:8];
         REG_SPL:   return m_sp[3:0];
         REG_SPH:   return m_sp[7:4];
         REG_IMM:   return im;
         REG_ALU, REG_ALU_WITH_FLAGS: return al;
         REG_HARDCODED_1: return 4'h1;
         REG_FLAGS: return {m_i, m_d, m_z, m_c};
         default:   return rd;
      endcase
   endfunction

   task automatic model_reset();
      m_a = 0; m_b = 0; m_ta = 0; m_tb = 0;
      m_x = 0; m_y = 0; m_sp = 0; m_addr = 0;
      m_c = 0; m_z = 0; m_d = 0; m_i = 0;
      for (int k = 0; k < 4096; k++) exp_mem[k] = 4'h0;
   endtask

   task automatic uop(input reg_type s, input reg_type dd, input reg_inc_type inc,
                      input logic [3:0] im, input logic [3:0] al, input logic zr, input logic cr);
      logic [11:0] ea;
      logic [3:0]  eb;
      reg_type     asel;
      asel = is_mem(s) ? s : dd;
      case (asel)
         REG_MX:  ea = m_x;
         REG_MY:  ea = m_y;
         REG_MN:  ea = {8'h00, im};
         REG_MSP: ea = {4'h0, m_sp};
         default: ea = 12'h000;
      endcase
      @(posedge clk); #1;
      current_cycle = CYCLE_REG_FETCH;
      bus_input_selector = s; bus_output_selector = dd; increment_selector = inc;
      immed = im; alu = al; alu_zero = zr; alu_carry = cr;
      @(negedge clk);
      chk("fetch_addr", memory_addr, ea);
      chk("fetch_wen", {11'd0, memory_write_en}, 12'd0);
      @(posedge clk); #1;
      current_cycle = CYCLE_REG_WRITE;
      eb = model_bus(s, im, al, exp_mem[ea]);
      @(negedge clk);
      chk("write_addr", memory_addr, ea);
      chk("write_wen", {11'd0, memory_write_en}, {11'd0, is_mem(dd)});
      chk("write_data", {8'd0, memory_write_data}, {8'd0, eb});
      last_wdata = memory_write_data;
      @(posedge clk); #1;
      current_cycle = CYCLE_NONE;
      m_addr = ea;
      if (is_mem(dd)) exp_mem[ea] = eb;
      if (inc == REG_XHL) m_x[7:0] = m_x[7:0] + 8'd1;
      if (inc == REG_YHL) m_y[7:0] = m_y[7:0] + 8'd1;
      if (inc == REG_SP)  m_sp = m_sp + 8'd1;
      if (s == REG_ALU_WITH_FLAGS) begin m_c = cr; m_z = zr; end
      case (dd)
         REG_A:     m_a = eb;
         REG_B:     m_b = eb;
         REG_TEMPA: m_ta = eb;
         REG_TEMPB: m_tb = eb;
         REG_XL:    m_x[3:0] = eb;
         REG_XH:    m_x[7:4] = eb;
         REG_XP:    m_x[11:8] = eb;
         REG_YL:    m_y[3:0] = eb;
         REG_YH:    m_y[7:4] = eb;
         REG_YP:    m_y[11:8] = eb;
         REG_SPL:   m_sp[3:0] = eb;
         REG_SPH:   m_sp[7:4] = eb;
         REG_FLAGS: {m_i, m_d, m_z, m_c} = eb;
         default:   ;
      endcase
      @(negedge clk);
      chk("idle_wen", {11'd0, memory_write_en}, 12'd0);
      chk("idle_addr", memory_addr, m_addr);
   endtask

   task automatic mv(input reg_type s, input reg_type dd, input logic [3:0] im);
      uop(s, dd, REG_NONE, im, 4'h0, 1'b0, 1'b0);
   endtask

   task automatic rd(input string tag, input reg_type s, input logic [3:0] expv);
      uop(s, REG_IMM, REG_NONE, 4'h0, 4'h0, 1'b0, 1'b0);
      chk(tag, {8'd0, last_wdata}, {8'd0, expv});
   endtask

   initial begin
      int bad;
      reg_type rs [17];
      rs = '{REG_A, REG_B, REG_TEMPA, REG_TEMPB, REG_XL, REG_XH, REG_XP, REG_YL, REG_YH,
             REG_YP, REG_SPL, REG_SPH, REG_FLAGS, REG_MX, REG_MY, REG_MN, REG_MSP};
      reset_n = 1'b0;
      current_cycle = CYCLE_NONE;
      bus_input_selector = REG_A; bus_output_selector = REG_IMM; increment_selector = REG_NONE;
      alu = 0; alu_zero = 0; alu_carry = 0; immed = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_addr", memory_addr, 12'h000);
      chk("reset_wen", {11'd0, memory_write_en}, 12'd0);
      reset_n = 1'b1;
      for (int k = 0; k < 13; k++) rd("reset_reg", rs[k], 4'h0);

      // Immediates and register moves
      mv(REG_IMM, REG_A, 4'hF);
      mv(REG_IMM, REG_B, 4'hA);
      mv(REG_A, REG_TEMPB, 0);
      mv(REG_B, REG_TEMPA, 0);
      rd("tempb", REG_TEMPB, 4'hF);
      rd("tempa", REG_TEMPA, 4'hA);
      mv(REG_IMM, REG_XL, 4'h5); mv(REG_IMM, REG_XH, 4'h4); mv(REG_IMM, REG_XP, 4'h3);
      rd("xl", REG_XL, 4'h5); rd("xp", REG_XP, 4'h3);
      mv(REG_IMM, REG_YL, 4'hD); mv(REG_IMM, REG_YH, 4'hE); mv(REG_IMM, REG_YP, 4'hF);
      mv(REG_IMM, REG_SPL, 4'h7); mv(REG_IMM, REG_SPH, 4'hF);

      // Seed RAM through the DUT, then read it back via each memory selector
      mv(REG_IMM, REG_MX, 4'h1);
      mv(REG_IMM, REG_MY, 4'hC);
      mv(REG_IMM, REG_A, 4'h4);
      mv(REG_A, REG_MN, 4'h7);
      mv(REG_IMM, REG_MSP, 4'hF);
      mv(REG_MX, REG_A, 0);
      chk("mx_addr", memory_addr, 12'h345);
      rd("mx_a", REG_A, 4'h1);
      mv(REG_MY, REG_B, 0);
      chk("my_addr", memory_addr, 12'hFED);
      rd("my_b", REG_B, 4'hC);
      mv(REG_MN, REG_TEMPA, 4'h7);
      chk("mn_addr", memory_addr, 12'h007);
      rd("mn_tempa", REG_TEMPA, 4'h4);
      mv(REG_MSP, REG_TEMPB, 0);
      chk("msp_addr", memory_addr, 12'h0F7);
      rd("msp_tempb", REG_TEMPB, 4'hF);
      mv(REG_TEMPB, REG_MX, 0);
      mv(REG_B, REG_MSP, 0);
      mv(REG_MX, REG_MSP, 0);

      // Post-increment
      mv(REG_IMM, REG_TEMPA, 4'h4);
      uop(REG_TEMPA, REG_MX, REG_XHL, 0, 0, 0, 0);
      chk("postinc_addr", memory_addr, 12'h345);
      rd("x_inc_l", REG_XL, 4'h6); rd("x_inc_h", REG_XH, 4'h4);
      mv(REG_IMM, REG_YL, 4'hF); mv(REG_IMM, REG_YH, 4'hF); mv(REG_IMM, REG_YP, 4'h2);
      uop(REG_YL, REG_MY, REG_YHL, 0, 0, 0, 0);
      chk("y_wrap_addr", memory_addr, 12'h2FF);
      rd("y_wrap_l", REG_YL, 4'h0); rd("y_wrap_h", REG_YH, 4'h0); rd("y_wrap_p", REG_YP, 4'h2);
      uop(REG_SPL, REG_A, REG_SP, 0, 0, 0, 0);
      rd("sp_a", REG_A, 4'h7); rd("sp_l", REG_SPL, 4'h8); rd("sp_h", REG_SPH, 4'hF);
      uop(REG_IMM, REG_XL, REG_XHL, 4'h9, 0, 0, 0);
      rd("inc_vs_dst", REG_XL, 4'h9);

      // Flags
      mv(REG_IMM, REG_FLAGS, 4'hF);
      rd("flags_f", REG_FLAGS, 4'hF);
      mv(REG_FLAGS, REG_TEMPA, 0);
      rd("flags_tempa", REG_TEMPA, 4'hF);
      uop(REG_ALU, REG_FLAGS, REG_NONE, 0, 4'h5, 1'b0, 1'b0);
      rd("flags_5", REG_FLAGS, 4'h5);
      uop(REG_ALU_WITH_FLAGS, REG_A, REG_NONE, 0, 4'h8, 1'b1, 1'b0);
      rd("awf_a", REG_A, 4'h8); rd("awf_flags", REG_FLAGS, 4'h6);
      uop(REG_ALU, REG_B, REG_NONE, 0, 4'hF, 1'b1, 1'b1);
      rd("alu_b", REG_B, 4'hF); rd("alu_noflags", REG_FLAGS, 4'h6);
      uop(REG_ALU_WITH_FLAGS, REG_FLAGS, REG_NONE, 0, 4'h9, 1'b0, 1'b0);
      rd("flags_win", REG_FLAGS, 4'h9);

      // Reset in the middle of a microinstruction
      @(posedge clk); #1;
      current_cycle = CYCLE_REG_FETCH;
      bus_input_selector = REG_IMM; bus_output_selector = REG_A; immed = 4'hB;
      @(posedge clk); #1;
      current_cycle = CYCLE_REG_WRITE;
      #2 reset_n = 1'b0;
      #1;
      chk("midreset_addr", memory_addr, 12'h000);
      chk("midreset_wen", {11'd0, memory_write_en}, 12'd0);
      @(posedge clk); #1;
      current_cycle = CYCLE_NONE;
      reset_n = 1'b1;
      model_reset();
      rd("midreset_a", REG_A, 4'h0);
      rd("midreset_flags", REG_FLAGS, 4'h0);

      // Random microinstructions
      for (int n = 0; n < 400; n++) begin
         uop(reg_type'($urandom_range(0, 20)), reg_type'($urandom_range(0, 20)),
             reg_inc_type'($urandom_range(0, 3)), 4'($urandom), 4'($urandom),
             1'($urandom), 1'($urandom));
      end
      for (int k = 0; k < 17; k++) mv(rs[k], REG_IMM, 4'($urandom));

      bad = 0;
      for (int k = 0; k < 4096; k++) if (ram[k] !== exp_mem[k]) bad++;
      chk("ram_contents", 12'(bad), 12'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
